// File: rtl/pf_lanectrl_pkg.sv
// Shared types for the lane-control pause sequencer.
// FSM state encodings used by pf_lanectrl_pause_seq.
package pf_lanectrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_LOAD = 3'd2,
    ST_POST = 3'd3,
    ST_ACK  = 3'd4
  } state_e;

  localparam int UPD_CNT_W = 16;

endpackage

// File: rtl/pf_lanectrl_dwell_cnt.sv
// Loadable down-counter with zero flag for state dwell timing.
// Holds at zero until reloaded, so it never wraps.
module pf_lanectrl_dwell_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pf_lanectrl_pause_seq.sv
// Pause / delay-load / settle / ack sequencer for lane delay updates.
// Define PF_LANECTRL_PAUSE_SEQ_CNT_EN to add the UPDATE_COUNT port.
module pf_lanectrl_pause_seq
  import pf_lanectrl_pkg::*;
#(
  parameter int PRE_PAUSE_CYCLES  = 2,
  parameter int LOAD_CYCLES       = 1,
  parameter int POST_PAUSE_CYCLES = 3,
  parameter int CODE_W            = 8,
  parameter int CNT_W             = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              UPDATE_REQ,
  input  logic [CODE_W-1:0] UPDATE_CODE,
  output logic              UPDATE_ACK,
  output logic              BUSY,
  output logic              HS_IO_CLK_PAUSE,
  output logic              DELAY_LOAD,
`ifdef PF_LANECTRL_PAUSE_SEQ_CNT_EN
  output logic [15:0]       UPDATE_COUNT,
`endif
  output logic [CODE_W-1:0] DELAY_CODE
);

  localparam logic [CNT_W-1:0] PRE_L  = CNT_W'(PRE_PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_L = CNT_W'(POST_PAUSE_CYCLES - 1);

  state_e            st_q, st_d;
  logic              cnt_ld;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              pause_q, load_q, ack_q, busy_q;
  logic [CODE_W-1:0] code_q;

  pf_lanectrl_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .load_i  (cnt_ld),
    .val_i   (cnt_val),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    st_d    = st_q;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    unique case (st_q)
      ST_IDLE: if (UPDATE_REQ) begin
        st_d    = ST_PRE;
        cnt_ld  = 1'b1;
        cnt_val = PRE_L;
      end
      ST_PRE: if (cnt_zero) begin
        st_d    = ST_LOAD;
        cnt_ld  = 1'b1;
        cnt_val = LOAD_L;
      end
      ST_LOAD: if (cnt_zero) begin
        st_d    = ST_POST;
        cnt_ld  = 1'b1;
        cnt_val = POST_L;
      end
      ST_POST: if (cnt_zero) st_d = ST_ACK;
      ST_ACK:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q    <= ST_IDLE;
      pause_q <= 1'b0;
      load_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      st_q    <= st_d;
      pause_q <= (st_d == ST_PRE) || (st_d == ST_LOAD) ||
                 (st_d == ST_POST);
      load_q  <= (st_d == ST_LOAD);
      ack_q   <= (st_d == ST_ACK);
      busy_q  <= (st_d != ST_IDLE);
      if (st_q == ST_IDLE && UPDATE_REQ) code_q <= UPDATE_CODE;
    end
  end

`ifdef PF_LANECTRL_PAUSE_SEQ_CNT_EN
  logic [UPD_CNT_W-1:0] upd_cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      upd_cnt_q <= '0;
    end else if (st_q == ST_ACK && upd_cnt_q != '1) begin
      upd_cnt_q <= upd_cnt_q + UPD_CNT_W'(1);
    end
  end

  assign UPDATE_COUNT = upd_cnt_q;
`endif

  assign UPDATE_ACK      = ack_q;
  assign BUSY            = busy_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign DELAY_LOAD      = load_q;
  assign DELAY_CODE      = code_q;

endmodule

// File: tb/tb_pf_lanectrl_pause_seq.sv
// Directed bench for pf_lanectrl_pause_seq: default and 1/3/1 timing.
// Per-cycle output bits are packed into vectors and compared to constants.
module tb_pf_lanectrl_pause_seq;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       req, req_b;
  logic [7:0] code, code_b;
  logic       ack, busy, pause, load;
  logic       ack_b, busy_b, pause_b, load_b;
  logic [7:0] dcode, dcode_b;
`ifdef PF_LANECTRL_PAUSE_SEQ_CNT_EN
  logic [15:0] ucnt, ucnt_b;
`endif

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] pv, lv, av, bv;
  logic [7:0]  codes [32];

  always #5 CLK = ~CLK;

  pf_lanectrl_pause_seq u_dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .UPDATE_REQ      (req),
    .UPDATE_CODE     (code),
    .UPDATE_ACK      (ack),
    .BUSY            (busy),
    .HS_IO_CLK_PAUSE (pause),
    .DELAY_LOAD      (load),
`ifdef PF_LANECTRL_PAUSE_SEQ_CNT_EN
    .UPDATE_COUNT    (ucnt),
`endif
    .DELAY_CODE      (dcode)
  );

  pf_lanectrl_pause_seq #(
    .PRE_PAUSE_CYCLES  (1),
    .LOAD_CYCLES       (3),
    .POST_PAUSE_CYCLES (1)
  ) u_dut_b (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .UPDATE_REQ      (req_b),
    .UPDATE_CODE     (code_b),
    .UPDATE_ACK      (ack_b),
    .BUSY            (busy_b),
    .HS_IO_CLK_PAUSE (pause_b),
    .DELAY_LOAD      (load_b),
`ifdef PF_LANECTRL_PAUSE_SEQ_CNT_EN
    .UPDATE_COUNT    (ucnt_b),
`endif
    .DELAY_CODE      (dcode_b)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Record n cycles of DUT A; REQ drops on the ack_limit-th ACK,
  // earlier ACKs switch UPDATE_CODE to code2.
  task cap(input int n, input int ack_limit, input logic [7:0] code2,
           input bit tog);
    int acks;
    acks = 0;
    pv = '0; lv = '0; av = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      pv[i] = pause;
      lv[i] = load;
      av[i] = ack;
      bv[i] = busy;
      codes[i] = dcode;
      if (tog && busy) code = ~code;
      if (ack) begin
        acks++;
        if (acks >= ack_limit) req = 1'b0;
        else code = code2;
      end
    end
  endtask

  initial begin
    int bad;
    RESET_N = 1'b0;
    req = 1'b0; code = 8'h00;
    req_b = 1'b0; code_b = 8'h00;
    tick();
    tick();
    chk("rst_pause", {31'd0, pause}, 32'd0);
    chk("rst_load",  {31'd0, load},  32'd0);
    chk("rst_ack",   {31'd0, ack},   32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_code",  {24'd0, dcode}, 32'd0);
    RESET_N = 1'b1;
    tick();

    // 1: single update, default timing
    req = 1'b1; code = 8'h5A;
    cap(8, 1, 8'h00, 1'b0);
    chk("t1_pause", pv, 32'h0000_003F);
    chk("t1_load",  lv, 32'h0000_0004);
    chk("t1_ack",   av, 32'h0000_0040);
    chk("t1_busy",  bv, 32'h0000_007F);
    chk("t1_code",  {24'd0, dcode}, 32'h5A);

    // 2: REQ held over two sequences
    req = 1'b1; code = 8'h11;
    cap(18, 2, 8'h22, 1'b0);
    chk("t2_pause", pv, 32'h0000_3F3F);
    chk("t2_ack",   av, 32'h0000_4040);
    chk("t2_code1", {24'd0, codes[0]}, 32'h11);
    chk("t2_code8", {24'd0, codes[7]}, 32'h11);
    chk("t2_code9", {24'd0, codes[8]}, 32'h22);

    // 3: UPDATE_CODE toggles while busy
    req = 1'b1; code = 8'h3C;
    cap(10, 1, 8'h00, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) if (codes[i] !== 8'h3C) bad++;
    chk("t3_stable", bad, 0);
    chk("t3_ack", av, 32'h0000_0040);

    // 4: reset during LOAD
    req = 1'b1; code = 8'h77;
    tick(); tick(); tick();
    chk("t4_inload", {31'd0, load}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("t4_pause", {31'd0, pause}, 32'd0);
    chk("t4_load",  {31'd0, load},  32'd0);
    chk("t4_busy",  {31'd0, busy},  32'd0);
    chk("t4_code",  {24'd0, dcode}, 32'd0);
    req = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    cap(10, 1, 8'h00, 1'b0);
    chk("t4_noack",   av, 32'd0);
    chk("t4_nopause", pv, 32'd0);
    req = 1'b1; code = 8'h42;
    cap(8, 1, 8'h00, 1'b0);
    chk("t4_re_pause", pv, 32'h0000_003F);
    chk("t4_re_ack",   av, 32'h0000_0040);
    chk("t4_re_code",  {24'd0, dcode}, 32'h42);

    // 5: PRE=1 LOAD=3 POST=1 instance
    req_b = 1'b1; code_b = 8'hA5;
    pv = '0; lv = '0; av = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pv[i] = pause_b;
      lv[i] = load_b;
      av[i] = ack_b;
      if (ack_b) req_b = 1'b0;
    end
    chk("t5_pause", pv, 32'h0000_001F);
    chk("t5_load",  lv, 32'h0000_000E);
    chk("t5_ack",   av, 32'h0000_0020);
    chk("t5_code",  {24'd0, dcode_b}, 32'hA5);

`ifdef PF_LANECTRL_PAUSE_SEQ_CNT_EN
    chk("cnt_a", {16'd0, ucnt},   32'd1);
    chk("cnt_b", {16'd0, ucnt_b}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
